// File: rtl/button_event.sv
`default_nettype none
// ============================================================================
// Module   : button_event
// Purpose  : Per-channel button gesture classifier. Each channel watches a
//            debounced, clk-synchronous level and reports short presses,
//            long presses, double presses and auto-repeat ticks while held.
// Ports    : clk          - clock, rising edge active
//            rst_n        - asynchronous active-low reset
//            clear        - synchronous abort of every channel
//            btn_in       - [N_CH] button levels, 1 = pressed
//            short_press  - [N_CH] one-cycle pulse, short press completed
//            long_press   - [N_CH] one-cycle pulse, long-press threshold hit
//            double_press - [N_CH] one-cycle pulse, second press in window
//            repeat_press - [N_CH] one-cycle pulse, auto-repeat tick in hold
//            held         - [N_CH] level, channel currently in HOLD
// Revision : 1.0 - initial release
// ============================================================================
module button_event #(
  parameter int N_CH       = 4,
  parameter int CNT_W      = 16,
  parameter int LONG_CYC   = 1000,
  parameter int DBL_EN     = 1,
  parameter int DBL_GAP    = 250,
  parameter int REPEAT_CYC = 200
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  input  logic [N_CH-1:0] btn_in,
  output logic [N_CH-1:0] short_press,
  output logic [N_CH-1:0] long_press,
  output logic [N_CH-1:0] double_press,
  output logic [N_CH-1:0] repeat_press,
  output logic [N_CH-1:0] held
);

  // Terminal counts: each phase ends when the counter shows the last value
  // of its window, so the qualifying sample is the one that makes it fire.
  localparam logic [CNT_W-1:0] c_LONG_LAST = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] c_GAP_LAST  = CNT_W'(DBL_GAP - 1);
  localparam logic [CNT_W-1:0] c_REP_LAST  = CNT_W'((REPEAT_CYC > 0) ? (REPEAT_CYC - 1) : 0);
  localparam logic [CNT_W-1:0] c_CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_CNT_MAX   = '1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PRESS  = 3'd1,
    S_GAP    = 3'd2,
    S_PRESS2 = 3'd3,
    S_HOLD   = 3'd4
  } state_t;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_short, r_long, r_dbl, r_rep, r_held;
    logic             w_short_nxt, w_long_nxt, w_dbl_nxt, w_rep_nxt;
    logic             w_btn;

    assign w_btn = btn_in[g];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_state <= S_IDLE;
        r_cnt   <= '0;
        r_short <= 1'b0;
        r_long  <= 1'b0;
        r_dbl   <= 1'b0;
        r_rep   <= 1'b0;
        r_held  <= 1'b0;
      end else begin
        r_state <= w_state_nxt;
        r_cnt   <= w_cnt_nxt;
        r_short <= w_short_nxt;
        r_long  <= w_long_nxt;
        r_dbl   <= w_dbl_nxt;
        r_rep   <= w_rep_nxt;
        // Registered copy of "next state is HOLD" so held tracks the state
        // with the same one-cycle latency as the pulses.
        r_held  <= (w_state_nxt == S_HOLD);
      end
    end

    always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_short_nxt = 1'b0;
      w_long_nxt  = 1'b0;
      w_dbl_nxt   = 1'b0;
      w_rep_nxt   = 1'b0;

      if (clear) begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_btn) begin
              w_state_nxt = S_PRESS;
              w_cnt_nxt   = c_CNT_ONE;
            end
          end
          S_PRESS: begin
            if (w_btn) begin
              if (r_cnt == c_LONG_LAST) begin
                w_state_nxt = S_HOLD;
                w_cnt_nxt   = '0;
                w_long_nxt  = 1'b1;
              end else begin
                w_cnt_nxt   = r_cnt + c_CNT_ONE;
              end
            end else if (DBL_EN != 0) begin
              // Short press is only reported once the gap proves no
              // second press follows.
              w_state_nxt = S_GAP;
              w_cnt_nxt   = c_CNT_ONE;
            end else begin
              w_state_nxt = S_IDLE;
              w_cnt_nxt   = '0;
              w_short_nxt = 1'b1;
            end
          end
          S_GAP: begin
            if (w_btn) begin
              w_state_nxt = S_PRESS2;
              w_cnt_nxt   = '0;
              w_dbl_nxt   = 1'b1;
            end else if (r_cnt == c_GAP_LAST) begin
              w_state_nxt = S_IDLE;
              w_cnt_nxt   = '0;
              w_short_nxt = 1'b1;
            end else begin
              w_cnt_nxt   = r_cnt + c_CNT_ONE;
            end
          end
          S_PRESS2: begin
            // Second press is consumed silently: no long press or repeat.
            if (!w_btn) begin
              w_state_nxt = S_IDLE;
              w_cnt_nxt   = '0;
            end
          end
          S_HOLD: begin
            if (!w_btn) begin
              w_state_nxt = S_IDLE;
              w_cnt_nxt   = '0;
            end else if ((REPEAT_CYC > 0) && (r_cnt == c_REP_LAST)) begin
              w_cnt_nxt   = '0;
              w_rep_nxt   = 1'b1;
            end else if (r_cnt != c_CNT_MAX) begin
              w_cnt_nxt   = r_cnt + c_CNT_ONE;
            end
          end
          default: begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
          end
        endcase
      end
    end

    assign short_press[g]  = r_short;
    assign long_press[g]   = r_long;
    assign double_press[g] = r_dbl;
    assign repeat_press[g] = r_rep;
    assign held[g]         = r_held;
  end

endmodule
`default_nettype wire

// File: tb/tb_button_event.sv
`default_nettype none
// ============================================================================
// Module   : tb_button_event
// Purpose  : Self-checking bench for button_event. Two instances share the
//            stimulus: one with double-press detection, one without. Outputs
//            are compared against a run-length reference model, a table of
//            directed vectors and hand-written multi-cycle sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_button_event;

  localparam int LONG = 8;
  localparam int GAP  = 4;
  localparam int REP  = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear = 1'b0;
  logic [1:0] btn = 2'b00;

  logic [1:0] sh_a, lg_a, db_a, rp_a, hd_a;
  logic [1:0] sh_b, lg_b, db_b, rp_b, hd_b;

  int n_checks = 0;
  int n_errors = 0;

  button_event #(.N_CH(2), .CNT_W(8), .LONG_CYC(LONG), .DBL_EN(1),
                 .DBL_GAP(GAP), .REPEAT_CYC(REP)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .btn_in(btn),
    .short_press(sh_a), .long_press(lg_a), .double_press(db_a),
    .repeat_press(rp_a), .held(hd_a));

  button_event #(.N_CH(2), .CNT_W(8), .LONG_CYC(LONG), .DBL_EN(0),
                 .DBL_GAP(GAP), .REPEAT_CYC(REP)) dut_nodbl (
    .clk(clk), .rst_n(rst_n), .clear(clear), .btn_in(btn),
    .short_press(sh_b), .long_press(lg_b), .double_press(db_b),
    .repeat_press(rp_b), .held(hd_b));

  always #5 clk = ~clk;

  // ---------------- reference model (run lengths, not states) -------------
  // k = 0: double-press enabled instance, k = 1: disabled instance.
  int         hi  [2][2];   // consecutive high samples of the current press
  int         lo  [2][2];   // low samples since a short first press released
  bit         pend[2][2];   // double-press window open
  bit         sec [2][2];   // current press is the second of a double
  logic [1:0] e_sh[2], e_lg[2], e_db[2], e_rp[2], e_hd[2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < 2; c++) begin
        hi[k][c] = 0; lo[k][c] = 0; pend[k][c] = 0; sec[k][c] = 0;
      end
      e_sh[k] = 0; e_lg[k] = 0; e_db[k] = 0; e_rp[k] = 0; e_hd[k] = 0;
    end
  endtask

  task automatic model_step(input logic [1:0] b, input logic clr);
    for (int k = 0; k < 2; k++) begin
      e_sh[k] = 0; e_lg[k] = 0; e_db[k] = 0; e_rp[k] = 0; e_hd[k] = 0;
      for (int c = 0; c < 2; c++) begin
        if (clr) begin
          hi[k][c] = 0; lo[k][c] = 0; pend[k][c] = 0; sec[k][c] = 0;
        end else if (b[c]) begin
          hi[k][c]++;
          if (hi[k][c] == 1) begin
            sec[k][c] = pend[k][c];
            if (pend[k][c]) e_db[k][c] = 1'b1;
            pend[k][c] = 0;
          end
          if (!sec[k][c]) begin
            if (hi[k][c] == LONG) e_lg[k][c] = 1'b1;
            else if (hi[k][c] > LONG && ((hi[k][c] - LONG) % REP) == 0) e_rp[k][c] = 1'b1;
          end
        end else begin
          if (hi[k][c] > 0) begin
            if (!sec[k][c] && hi[k][c] < LONG) begin
              if (k == 0) begin pend[k][c] = 1; lo[k][c] = 1; end
              else e_sh[k][c] = 1'b1;
            end
            hi[k][c] = 0; sec[k][c] = 0;
          end else if (pend[k][c]) begin
            lo[k][c]++;
            if (lo[k][c] == GAP) begin e_sh[k][c] = 1'b1; pend[k][c] = 0; end
          end
        end
        e_hd[k][c] = !sec[k][c] && hi[k][c] >= LONG;
      end
    end
  endtask

  // ---------------- checking helpers --------------------------------------
  task automatic chk(input string nm, input logic [1:0] act, input logic [1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_model();
    chk("dbl.short",  sh_a, e_sh[0]); chk("dbl.long",   lg_a, e_lg[0]);
    chk("dbl.double", db_a, e_db[0]); chk("dbl.repeat", rp_a, e_rp[0]);
    chk("dbl.held",   hd_a, e_hd[0]);
    chk("nod.short",  sh_b, e_sh[1]); chk("nod.long",   lg_b, e_lg[1]);
    chk("nod.double", db_b, e_db[1]); chk("nod.repeat", rp_b, e_rp[1]);
    chk("nod.held",   hd_b, e_hd[1]);
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled
  // at the same point, after the DUT has registered the previous sample.
  task automatic step(input logic [1:0] b, input logic clr = 1'b0);
    btn = b; clear = clr;
    @(posedge clk); #1;
    model_step(b, clr);
    cmp_model();
  endtask

  // ---------------- directed vector table ---------------------------------
  typedef struct {
    logic [1:0] b;
    logic [1:0] sh, lg, db, rp, hd;
  } vec_t;

  function automatic vec_t mk(input logic [1:0] b, sh, lg, db, rp, hd);
    vec_t v;
    v.b = b; v.sh = sh; v.lg = lg; v.db = db; v.rp = rp; v.hd = hd;
    return v;
  endfunction

  vec_t tbl[19];

  initial begin
    // ch0: 3 high then gap -> short on 4th low.  ch0: 7 high -> still short
    // (via gap) while ch1: 8 high -> long, then repeat in the same cycle
    // as ch0's short.
    for (int i = 0; i < 3; i++)  tbl[i] = mk(2'b01, 0, 0, 0, 0, 0);
    for (int i = 3; i < 6; i++)  tbl[i] = mk(2'b00, 0, 0, 0, 0, 0);
    tbl[6] = mk(2'b00, 2'b01, 0, 0, 0, 0);
    for (int i = 7; i < 14; i++) tbl[i] = mk(2'b11, 0, 0, 0, 0, 0);
    tbl[14] = mk(2'b10, 0, 2'b10, 0, 0, 2'b10);
    tbl[15] = mk(2'b10, 0, 0, 0, 0, 2'b10);
    tbl[16] = mk(2'b10, 0, 0, 0, 0, 2'b10);
    tbl[17] = mk(2'b10, 2'b01, 0, 0, 2'b10, 2'b10);
    tbl[18] = mk(2'b00, 0, 0, 0, 0, 0);

    model_reset();
    #2;
    chk("reset.pulses", sh_a | lg_a | db_a | rp_a | sh_b | lg_b | db_b | rp_b, 2'b00);
    chk("reset.held",   hd_a | hd_b, 2'b00);
    @(negedge clk); rst_n = 1'b1;

    // Table vectors
    for (int i = 0; i < 19; i++) begin
      step(tbl[i].b);
      chk($sformatf("tbl%0d.short", i),  sh_a, tbl[i].sh);
      chk($sformatf("tbl%0d.long", i),   lg_a, tbl[i].lg);
      chk($sformatf("tbl%0d.double", i), db_a, tbl[i].db);
      chk($sformatf("tbl%0d.repeat", i), rp_a, tbl[i].rp);
      chk($sformatf("tbl%0d.held", i),   hd_a, tbl[i].hd);
    end
    for (int i = 0; i < 6; i++) step(2'b00);

    // 7 high then low without double detection: short right at release
    for (int i = 0; i < 7; i++) begin
      step(2'b01);
      chk("nodbl7.long", lg_b, 2'b00);
    end
    step(2'b00);
    chk("nodbl7.short", sh_b, 2'b01);
    for (int i = 0; i < 5; i++) step(2'b00);

    // 14 high: long at 8, repeats at 11 and 14, release silent
    for (int i = 1; i <= 14; i++) begin
      step(2'b01);
      chk("hold14.long",   lg_a, (i == 8) ? 2'b01 : 2'b00);
      chk("hold14.repeat", rp_a, (i == 11 || i == 14) ? 2'b01 : 2'b00);
      chk("hold14.held",   hd_a, (i >= 8) ? 2'b01 : 2'b00);
    end
    step(2'b00);
    chk("hold14.rel_held",  hd_a, 2'b00);
    chk("hold14.rel_short", sh_a, 2'b00);
    for (int i = 0; i < 5; i++) begin
      step(2'b00);
      chk("hold14.no_short", sh_a, 2'b00);
    end

    // ch1 double press: high 2, low 2, high 20, low
    step(2'b10); step(2'b10); step(2'b00); step(2'b00);
    for (int i = 1; i <= 20; i++) begin
      step(2'b10);
      chk("dbl.double_pulse", db_a, (i == 1) ? 2'b10 : 2'b00);
      chk("dbl.quiet", lg_a | rp_a | sh_a | hd_a, 2'b00);
    end
    for (int i = 0; i < 5; i++) begin
      step(2'b00);
      chk("dbl.after", sh_a | lg_a | db_a | rp_a, 2'b00);
    end

    // ch0 held while ch1 short-presses, then clear
    for (int i = 0; i < 8; i++) step(2'b01);
    chk("clr.pre_held", hd_a, 2'b01);
    for (int i = 0; i < 3; i++) step(2'b11);
    step(2'b01); step(2'b01); step(2'b01); step(2'b01);
    chk("clr.ch1_short", sh_a, 2'b10);
    step(2'b11, 1'b1);
    chk("clr.held",   hd_a | hd_b, 2'b00);
    chk("clr.pulses", sh_a | lg_a | db_a | rp_a | sh_b | lg_b | db_b | rp_b, 2'b00);
    for (int i = 1; i <= 8; i++) begin
      step(2'b11);
      chk("clr.relong", lg_a, (i == 8) ? 2'b11 : 2'b00);
    end
    for (int i = 0; i < 6; i++) step(2'b00);

    // Async reset mid-press (ch0 cnt=5) while ch1 is held
    for (int i = 0; i < 9; i++) step(2'b10);
    for (int i = 0; i < 5; i++) step(2'b11);
    chk("rst.pre_held", hd_a, 2'b10);
    rst_n = 1'b0;
    #1;
    chk("rst.held_now",   hd_a | hd_b, 2'b00);
    chk("rst.pulses_now", sh_a | lg_a | db_a | rp_a | sh_b | lg_b | db_b | rp_b, 2'b00);
    model_reset();
    @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step(2'b11);
      chk("rst.long", lg_a, (i == 8) ? 2'b11 : 2'b00);
    end
    for (int i = 0; i < 6; i++) step(2'b00);

    // Randomized run against the model
    begin
      logic [1:0] b;
      b = 2'b00;
      for (int n = 0; n < 3000; n++) begin
        for (int c = 0; c < 2; c++)
          if ($urandom_range(5) == 0) b[c] = ~b[c];
        step(b, ($urandom_range(59) == 0) ? 1'b1 : 1'b0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
